// File: rtl/vxe_vpu_cmd_dispatcher_pkg.sv
// Shared types and constants for the VPU command dispatcher.
// Holds the control-unit opcode map (CU_CMD_*) and the fixed command-field widths.
package vxe_vpu_cmd_dispatcher_pkg;

  localparam int OP_W = 5;
  localparam int TH_W = 3;
  localparam int PL_W = 48;
  localparam int FU_N = 4;

  // Control-unit command opcodes
  localparam logic [OP_W-1:0] CU_CMD_NOP    = 5'h00;
  localparam logic [OP_W-1:0] CU_CMD_SETACC = 5'h01;
  localparam logic [OP_W-1:0] CU_CMD_SETVL  = 5'h02;
  localparam logic [OP_W-1:0] CU_CMD_SETEN  = 5'h03;
  localparam logic [OP_W-1:0] CU_CMD_SETRS  = 5'h04;
  localparam logic [OP_W-1:0] CU_CMD_SETRT  = 5'h05;
  localparam logic [OP_W-1:0] CU_CMD_SETRD  = 5'h06;
  localparam logic [OP_W-1:0] CU_CMD_PROD   = 5'h08;
  localparam logic [OP_W-1:0] CU_CMD_STORE  = 5'h09;
  localparam logic [OP_W-1:0] CU_CMD_ACTF   = 5'h0A;

  // Bit positions inside the functional-unit one-hot
  localparam int FU_REGU = 0;
  localparam int FU_PROD = 1;
  localparam int FU_STOR = 2;
  localparam int FU_ACTF = 3;

  typedef logic [FU_N-1:0] fu_vec_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [TH_W-1:0] th;
    logic [PL_W-1:0] pl;
  } fu_cmd_t;

endpackage

// File: rtl/vxe_vpu_cmd_decode.sv
// Combinational opcode decoder: maps a control-unit opcode to a functional-unit one-hot.
// Unknown opcodes decode to all-zero, which the dispatcher treats as "drop".
module vxe_vpu_cmd_decode
  import vxe_vpu_cmd_dispatcher_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output fu_vec_t         fu_sel
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives fu_sel; otherwise a latch is inferred.
    fu_sel = '0;
    case (op)
      CU_CMD_SETACC,
      CU_CMD_SETVL,
      CU_CMD_SETEN,
      CU_CMD_SETRS,
      CU_CMD_SETRT,
      CU_CMD_SETRD:  fu_sel[FU_REGU] = 1'b1;
      CU_CMD_PROD:   fu_sel[FU_PROD] = 1'b1;
      CU_CMD_STORE:  fu_sel[FU_STOR] = 1'b1;
      CU_CMD_ACTF:   fu_sel[FU_ACTF] = 1'b1;
      default:       fu_sel = '0;
    endcase
  end

endmodule

// File: rtl/vxe_vpu_cmd_dispatcher.sv
// VPU command dispatcher: pops one command at a time and hands it to a single functional unit.
// Optional simulation checks are enabled with the VXE_VPU_CMD_DISP_CHECK_EN macro.
module vxe_vpu_cmd_dispatcher
  import vxe_vpu_cmd_dispatcher_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            i_vld,
  output logic            o_rd,
  input  logic [OP_W-1:0] i_op,
  input  logic [TH_W-1:0] i_th,
  input  logic [PL_W-1:0] i_pl,
  output logic            o_busy,
  output logic            regu_disp,
  input  logic            regu_done,
  output logic            prod_disp,
  input  logic            prod_done,
  output logic            stor_disp,
  input  logic            stor_done,
  output logic            actf_disp,
  input  logic            actf_done,
  output logic [OP_W-1:0] fu_cmd_op,
  output logic [TH_W-1:0] fu_cmd_th,
  output logic [PL_W-1:0] fu_cmd_pl,
  output logic            regu_cmd,
  output logic            prod_cmd,
  output logic            stor_cmd,
  output logic            actf_cmd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DISP = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0] state_q, state_d;
  fu_vec_t    cmd_q, cmd_d;
  fu_vec_t    dec_sel;
  fu_vec_t    done_vec;
  fu_vec_t    disp_vec;
  fu_cmd_t    fu_cmd_q;
  logic       dec_known;
  logic       accept;
  logic       done_hit;

  vxe_vpu_cmd_decode u_decode (
    .op     (i_op),
    .fu_sel (dec_sel)
  );

  assign done_vec  = {actf_done, stor_done, prod_done, regu_done};
  assign dec_known = |dec_sel;
  assign o_rd      = (state_q == ST_IDLE) & i_vld;
  assign accept    = o_rd & dec_known;
  // Only the owning unit's done, seen in WAIT, ends the command.
  assign done_hit  = (state_q == ST_WAIT) & (|(cmd_q & done_vec));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DISP;
          cmd_d   = dec_sel;
        end
      end
      ST_DISP: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_hit) begin
          state_d = ST_IDLE;
          cmd_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cmd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      fu_cmd_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      if (accept) begin
        fu_cmd_q <= '{op: i_op, th: i_th, pl: i_pl};
      end
    end
  end

  assign disp_vec  = cmd_q & {FU_N{state_q == ST_DISP}};

  assign regu_disp = disp_vec[FU_REGU];
  assign prod_disp = disp_vec[FU_PROD];
  assign stor_disp = disp_vec[FU_STOR];
  assign actf_disp = disp_vec[FU_ACTF];

  assign regu_cmd  = cmd_q[FU_REGU];
  assign prod_cmd  = cmd_q[FU_PROD];
  assign stor_cmd  = cmd_q[FU_STOR];
  assign actf_cmd  = cmd_q[FU_ACTF];

  assign fu_cmd_op = fu_cmd_q.op;
  assign fu_cmd_th = fu_cmd_q.th;
  assign fu_cmd_pl = fu_cmd_q.pl;

  assign o_busy    = (state_q != ST_IDLE) | i_vld;

`ifdef VXE_VPU_CMD_DISP_CHECK_EN
  fu_vec_t stray_done;

  // Any done that is not the owner's done in WAIT is stray.
  assign stray_done = done_vec & ~(cmd_q & {FU_N{state_q == ST_WAIT}});

  always_ff @(posedge clk) begin
    if (nrst) begin
      if (|stray_done) begin
        $display("%t vxe_vpu_cmd_dispatcher error: stray done %b (owner %b, state %0d)",
                 $time, stray_done, cmd_q, state_q);
      end
      if (o_rd && !dec_known) begin
        $display("%t vxe_vpu_cmd_dispatcher error: dropped undecodable opcode 0x%0h",
                 $time, i_op);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vxe_vpu_cmd_dispatcher.sv
// Self-checking bench for vxe_vpu_cmd_dispatcher: directed steps followed by randomized commands,
// with expected behaviour derived from an opcode-to-unit table and per-command timing rules.
module tb_vxe_vpu_cmd_dispatcher;

  localparam logic [4:0] OP_SETACC = 5'h01;
  localparam logic [4:0] OP_SETVL  = 5'h02;
  localparam logic [4:0] OP_SETEN  = 5'h03;
  localparam logic [4:0] OP_SETRS  = 5'h04;
  localparam logic [4:0] OP_SETRT  = 5'h05;
  localparam logic [4:0] OP_SETRD  = 5'h06;
  localparam logic [4:0] OP_PROD   = 5'h08;
  localparam logic [4:0] OP_STORE  = 5'h09;
  localparam logic [4:0] OP_ACTF   = 5'h0A;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_vld;
  logic        o_rd;
  logic [4:0]  i_op;
  logic [2:0]  i_th;
  logic [47:0] i_pl;
  logic        o_busy;
  logic        regu_disp, prod_disp, stor_disp, actf_disp;
  logic        regu_done, prod_done, stor_done, actf_done;
  logic        regu_cmd, prod_cmd, stor_cmd, actf_cmd;
  logic [4:0]  fu_cmd_op;
  logic [2:0]  fu_cmd_th;
  logic [47:0] fu_cmd_pl;

  logic [3:0]  disp_vec, cmd_vec, done_drv;
  int          n_cmp = 0;
  int          n_err = 0;

  assign disp_vec = {actf_disp, stor_disp, prod_disp, regu_disp};
  assign cmd_vec  = {actf_cmd, stor_cmd, prod_cmd, regu_cmd};
  assign {actf_done, stor_done, prod_done, regu_done} = done_drv;

  always #5 clk = ~clk;

  vxe_vpu_cmd_dispatcher dut (
    .clk       (clk),
    .nrst      (nrst),
    .i_vld     (i_vld),
    .o_rd      (o_rd),
    .i_op      (i_op),
    .i_th      (i_th),
    .i_pl      (i_pl),
    .o_busy    (o_busy),
    .regu_disp (regu_disp),
    .regu_done (regu_done),
    .prod_disp (prod_disp),
    .prod_done (prod_done),
    .stor_disp (stor_disp),
    .stor_done (stor_done),
    .actf_disp (actf_disp),
    .actf_done (actf_done),
    .fu_cmd_op (fu_cmd_op),
    .fu_cmd_th (fu_cmd_th),
    .fu_cmd_pl (fu_cmd_pl),
    .regu_cmd  (regu_cmd),
    .prod_cmd  (prod_cmd),
    .stor_cmd  (stor_cmd),
    .actf_cmd  (actf_cmd)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: opcode -> owning unit (0 regu, 1 prod, 2 stor, 3 actf, -1 none)
  function automatic int ref_fu(input logic [4:0] op);
    case (op)
      OP_SETACC, OP_SETVL, OP_SETEN, OP_SETRS, OP_SETRT, OP_SETRD: return 0;
      OP_PROD:  return 1;
      OP_STORE: return 2;
      OP_ACTF:  return 3;
      default:  return -1;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one command from IDLE and walks it to completion; returns one cycle after
  // the DUT is back in IDLE. spur: non-owner dones driven while waiting; early: owner
  // done pulsed during the dispatch cycle; stall: queue stays non-empty while busy;
  // hold: owner done held one extra cycle into IDLE.
  task automatic run_cmd(input logic [4:0] op, input logic [2:0] th, input logic [47:0] pl,
                         input int delay, input logic [3:0] spur, input bit early,
                         input bit stall, input bit hold);
    int         fu;
    logic [3:0] oh;
    logic [55:0] exp_fields;
    fu = ref_fu(op);
    if (hold) stall = 1'b0;
    i_vld = 1'b1; i_op = op; i_th = th; i_pl = pl; done_drv = '0;
    #1;
    check("pop_rd", 64'(o_rd), 64'(1'b1));
    check("pop_busy", 64'(o_busy), 64'(1'b1));
    next_cycle();
    i_vld = stall;
    i_op  = 5'($urandom);
    i_th  = 3'($urandom);
    i_pl  = 48'({$urandom(), $urandom()});
    if (fu < 0) begin
      i_vld = 1'b0;
      #1;
      check("drop_disp", 64'(disp_vec), 64'(4'b0));
      check("drop_cmd", 64'(cmd_vec), 64'(4'b0));
      check("drop_busy", 64'(o_busy), 64'(1'b0));
      return;
    end
    oh = 4'b0001 << fu;
    exp_fields = {op, th, pl};
    if (early) done_drv = oh;
    #1;
    check("disp_vec", 64'(disp_vec), 64'(oh));
    check("disp_cmd", 64'(cmd_vec), 64'(oh));
    check("disp_fields", 64'({fu_cmd_op, fu_cmd_th, fu_cmd_pl}), 64'(exp_fields));
    check("disp_rd", 64'(o_rd), 64'(1'b0));
    check("disp_busy", 64'(o_busy), 64'(1'b1));
    for (int c = 0; c < delay; c++) begin
      next_cycle();
      done_drv = spur & ~oh;
      #1;
      check("wait_disp", 64'(disp_vec), 64'(4'b0));
      check("wait_cmd", 64'(cmd_vec), 64'(oh));
      check("wait_fields", 64'({fu_cmd_op, fu_cmd_th, fu_cmd_pl}), 64'(exp_fields));
      check("wait_rd", 64'(o_rd), 64'(1'b0));
      check("wait_busy", 64'(o_busy), 64'(1'b1));
    end
    next_cycle();
    done_drv = oh | (spur & ~oh);
    #1;
    check("done_cmd", 64'(cmd_vec), 64'(oh));
    check("done_fields", 64'({fu_cmd_op, fu_cmd_th, fu_cmd_pl}), 64'(exp_fields));
    check("done_rd", 64'(o_rd), 64'(1'b0));
    next_cycle();
    done_drv = hold ? oh : 4'b0;
    #1;
    check("after_cmd", 64'(cmd_vec), 64'(4'b0));
    check("after_rd", 64'(o_rd), 64'(stall));
    check("after_busy", 64'(o_busy), 64'(stall));
    if (hold) begin
      next_cycle();
      done_drv = '0;
      #1;
      check("hold_cmd", 64'(cmd_vec), 64'(4'b0));
      check("hold_disp", 64'(disp_vec), 64'(4'b0));
      check("hold_busy", 64'(o_busy), 64'(1'b0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [4:0] ops [0:8];
    ops = '{OP_SETACC, OP_SETVL, OP_SETEN, OP_SETRS, OP_SETRT, OP_SETRD,
            OP_PROD, OP_STORE, OP_ACTF};

    nrst = 1'b0; i_vld = 1'b0; i_op = '0; i_th = '0; i_pl = '0; done_drv = '0;
    #12;
    check("rst_disp", 64'(disp_vec), 64'(4'b0));
    check("rst_cmd", 64'(cmd_vec), 64'(4'b0));
    check("rst_rd", 64'(o_rd), 64'(1'b0));
    check("rst_busy", 64'(o_busy), 64'(1'b0));
    check("rst_fields", 64'({fu_cmd_op, fu_cmd_th, fu_cmd_pl}), 64'(0));
    next_cycle();
    nrst = 1'b1;
    next_cycle();

    // Register group: th 1..6, pl 0x1111..0x6666
    for (int k = 0; k < 6; k++)
      run_cmd(ops[k], 3'(k + 1), 48'h1111 * 48'(k + 1), k % 3, 4'b0, 1'b0, 1'b0, 1'b0);

    run_cmd(OP_PROD,  3'd7, 48'h7777, 2, 4'b0, 1'b0, 1'b0, 1'b0);
    run_cmd(OP_STORE, 3'd0, 48'h0,    1, 4'b0, 1'b0, 1'b0, 1'b0);
    run_cmd(OP_ACTF,  3'd1, 48'h1111, 0, 4'b0, 1'b0, 1'b0, 1'b0);

    // Stall: owner done 10 cycles late with the queue non-empty
    run_cmd(OP_SETVL, 3'd2, 48'h2222, 10, 4'b0, 1'b0, 1'b1, 1'b0);

    // prod_done while the register unit owns the command
    run_cmd(OP_SETACC, 3'd3, 48'hABCD, 3, 4'b0010, 1'b0, 1'b0, 1'b0);

    // Owner done during dispatch is ignored; held owner done does not retrigger
    run_cmd(OP_PROD, 3'd4, 48'h1234_5678_9ABC, 1, 4'b0, 1'b1, 1'b0, 1'b1);

    // Unknown opcodes: popped and dropped
    run_cmd(5'h07, 3'd5, 48'h5555, 0, 4'b0, 1'b0, 1'b0, 1'b0);
    run_cmd(5'h1F, 3'd6, 48'h6666, 0, 4'b0, 1'b0, 1'b0, 1'b0);

    // Reset pulsed while a command waits
    i_vld = 1'b1; i_op = OP_STORE; i_th = 3'd3; i_pl = 48'hDEAD;
    next_cycle();
    i_vld = 1'b0;
    next_cycle();
    check("mid_wait_cmd", 64'(cmd_vec), 64'(4'b0100));
    nrst = 1'b0;
    #1;
    check("mid_rst_cmd", 64'(cmd_vec), 64'(4'b0));
    check("mid_rst_disp", 64'(disp_vec), 64'(4'b0));
    check("mid_rst_busy", 64'(o_busy), 64'(1'b0));
    check("mid_rst_fields", 64'({fu_cmd_op, fu_cmd_th, fu_cmd_pl}), 64'(0));
    next_cycle();
    nrst = 1'b1;
    next_cycle();
    run_cmd(OP_ACTF, 3'd2, 48'hBEEF, 1, 4'b0, 1'b0, 1'b0, 1'b0);

    // Randomized commands
    for (int r = 0; r < 60; r++) begin
      logic [4:0] rop;
      if ($urandom_range(0, 3) == 0) rop = 5'($urandom);
      else rop = ops[$urandom_range(0, 8)];
      run_cmd(rop, 3'($urandom), 48'({$urandom(), $urandom()}),
              int'($urandom_range(0, 6)), 4'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
